yt_output_buf: RTL and testbench
================================

// Module: yt_output_buf
// PURPOSE
//  Write-side counterpart of the x_t input ROM: captures the compute core's 4-lane signed
//  result vectors (y_t) via valid/ready and packs each to one 64-bit word, little-endian.
//  Stores a frame of words at sequential addresses in a simple-dual-port RAM.
//  Independent read port (2-cycle latency, same as the x_t ROM) lets host/TB drain results.
//  Word format is identical to the x_t ROM, so images are interchangeable.
// PARAMETERS
//  ADDR_W     6   RAM address width; DEPTH = 1<<ADDR_W words
//  DATA_W     16  bits per signed element
//  TILE_SIZE  4   elements per word; WORD_W = TILE_SIZE*DATA_W (64)
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 synchronous, active-high reset
//  start      in   1                 1-cycle pulse: begin a frame (honoured only in IDLE)
//  frame_len  in   ADDR_W+1          words in frame, sampled on start; 0..DEPTH
//  in_valid   in   1                 din_vec valid
//  in_ready   out  1                 buffer accepts din_vec this cycle
//  din_vec    in   DATA_W x TILE     signed unpacked vector, lane 0 = bits [15:0]
//  busy       out  1                 frame in progress (state != IDLE)
//  done       out  1                 1-cycle pulse: frame complete
//  wr_cnt     out  ADDR_W+1          words accepted in current/last frame
//  len_err    out  1                 sticky: frame_len > DEPTH seen on start
//  rd_en      in   1                 read enable
//  rd_addr    in   ADDR_W            read address
//  rd_data    out  WORD_W            packed word, valid 2 cycles after rd_en
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, in_ready=0, busy=0, done=0, wr_cnt=0, len_err=0,
//   both read pipe stages=0. RAM contents are NOT cleared. Reset mid-frame aborts the frame, no done.
//  FSM IDLE -> FILL -> DONE -> IDLE.
//   IDLE: in_ready=0. start: latch len=min(frame_len,DEPTH), wr_cnt<=0, wr_addr<=0;
//     len==0 -> DONE, else -> FILL. frame_len>DEPTH sets len_err and clamps to DEPTH.
//   FILL: in_ready=1. Handshake = in_valid&in_ready at posedge; writes
//     {din[3],din[2],din[1],din[0]} to wr_addr, then wr_addr++ and wr_cnt++.
//     The accept that makes wr_cnt==len -> DONE; in_ready deasserts the next cycle.
//     in_valid=0 is a stall: no write, no count.
//   DONE: done=1 for exactly one cycle, in_ready=0 -> IDLE. wr_cnt holds until next start.
//  start outside IDLE is ignored. start and the final accept in the same cycle: start ignored.
//  in_valid while in_ready=0 is not an error; the producer holds data (no drop, no write).
//  Write address never wraps: max len=DEPTH, so the last address is DEPTH-1.
//  Read: stage1 <= ram[rd_addr] when rd_en; stage2 <= stage1 every cycle; rd_data=stage2.
//   rd_data holds when rd_en=0, with no zero forcing.
//   Read and write to the same address in one cycle: read-first, returns old data.
//  Packing is bit-exact two's complement; no saturation or sign manipulation.
// STRUCTURE
//  mamba_buf_pkg: WORD_W localparam, typedef vec_t (signed DATA_W x TILE_SIZE),
//   pack_vec()/unpack_word() functions. The x_t ROM and this block share these.
//  Sub-module sdp_ram_2lat: 1 write port, 1 read port, read-first, 2-cycle read.
//   Under `SYNTHESIS it wraps the BRAM IP; otherwise behavioural, mem_sim exposed to the TB.
//  Top-level: FSM + counters + pack logic (~150-250 lines).
// TESTING
//  T1 reset: rst=1 for 3 cycles mid-FILL -> in_ready=0, busy=0, wr_cnt=0, no done; RAM intact.
//  T2 frame_len=4, in_valid held high with vectors {1,-1,2,-2}.. -> 4 accepts in 4 cycles,
//   done pulses once, word0=64'hFFFE_0002_FFFF_0001.
//  T3 frame_len=3 with random in_valid gaps -> exactly 3 writes at addr 0..2, wr_cnt=3,
//   in_ready=0 after the 3rd accept even with in_valid=1.
//  T4 frame_len=0 -> done on the 2nd cycle after start, no write; frame_len=65 -> len_err=1,
//   64 writes, last at addr 63.
//  T5 rd_en to addr 2 in the same cycle as a write to addr 2 -> old word 2 cycles later;
//   re-read -> new word.
//  T6 start pulsed during FILL and on the final accept -> ignored; exactly one done per frame.

Source files
------------

// File: rtl/yt_output_buf_pkg.sv
// Shared word format for the x_t input ROM and the y_t output buffer.
// A word holds TILE_SIZE signed lanes, little-endian: lane 0 sits in bits [DATA_W-1:0].
package yt_output_buf_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TILE_SIZE = 4;
  localparam int unsigned WORD_W    = DATA_W * TILE_SIZE;

  typedef logic signed [DATA_W-1:0] vec_t [TILE_SIZE];
  typedef logic [WORD_W-1:0] word_t;

  // Bit-exact two's complement packing, no saturation.
  function automatic word_t pack_vec(input vec_t v);
    word_t w;
    w = '0;
    for (int unsigned i = 0; i < TILE_SIZE; i++) begin
      w[i*DATA_W +: DATA_W] = v[i];
    end
    return w;
  endfunction

  function automatic vec_t unpack_word(input word_t w);
    vec_t v;
    for (int unsigned i = 0; i < TILE_SIZE; i++) begin
      v[i] = w[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

endpackage

// File: rtl/yt_output_buf_if.sv
// Valid/ready stream carrying one y_t result vector per transfer.
interface yt_output_buf_if;
  import yt_output_buf_pkg::*;

  logic in_valid;
  logic in_ready;
  vec_t din_vec;

  modport master (
    output in_valid,
    output din_vec,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  din_vec,
    output in_ready
  );

endinterface

// File: rtl/yt_output_buf_sdp_ram_2lat.sv
// Simple-dual-port RAM: one write port, one read port, read-first, 2-cycle read latency.
// Contents are never reset; only the read pipeline is.
module yt_output_buf_sdp_ram_2lat
  import yt_output_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  word_t             wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output word_t             rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  word_t mem_sim [Depth];
  word_t stage1_q, stage1_d;
  word_t stage2_q, stage2_d;

  // Stage 1 loads only on a read; stage 2 follows every cycle, so rdata holds when idle.
  always_comb begin
    stage1_d = stage1_q;
    if (re_i) begin
      stage1_d = mem_sim[raddr_i];
    end
    stage2_d = stage1_q;
  end

  // Array write; the read above sees the pre-write contents (read-first).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_sim[waddr_i] <= wdata_i;
    end
  end

  // Read pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign rdata_o = stage2_q;

endmodule

// File: rtl/yt_output_buf.sv
// y_t output buffer: accepts a frame of result vectors over valid/ready, packs each into one
// word and stores them at sequential addresses; an independent read port drains the frame.
module yt_output_buf
  import yt_output_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  yt_output_buf_if.slave    in_if,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              len_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept;
  logic            last_accept;
  logic            too_long;
  word_t           wdata;

  // ready_q is only ever set while filling, so it alone qualifies the handshake.
  assign accept      = in_if.in_valid & ready_q;
  assign last_accept = accept & ((cnt_q + CntOne) == len_q);
  assign too_long    = frame_len > Depth;
  assign wdata       = pack_vec(in_if.din_vec);

  // Next-state for the frame FSM and all of its registered outputs.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d  = err_q | too_long;
          len_d  = too_long ? Depth : frame_len;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (frame_len == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFill;
            ready_d = 1'b1;
          end
        end
      end
      StFill: begin
        // A start here (including alongside the final accept) is deliberately ignored.
        if (accept) begin
          cnt_d = cnt_q + CntOne;
          if (last_accept) begin
            state_d = StDone;
            ready_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs; reset aborts any frame without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wr_cnt         = cnt_q;
  assign len_err        = err_q;

  // Write address equals the count of words already accepted; len <= DEPTH keeps it in range.
  yt_output_buf_sdp_ram_2lat #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (accept & ~rst),
    .waddr_i (cnt_q[ADDR_W-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_yt_output_buf.sv
// Randomised bench for yt_output_buf against a frame-level behavioural model.
module tb_yt_output_buf;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   frame_len;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_cnt;
  logic          len_err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;

  int checks = 0;
  int errors = 0;

  yt_output_buf_if u_if ();

  yt_output_buf #(
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .in_if     (u_if),
    .busy      (busy),
    .done      (done),
    .wr_cnt    (wr_cnt),
    .len_err   (len_err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Reference model: frame bookkeeping plus a word image of the RAM.
  int          cur [4];
  logic [63:0] m_mem [DEPTH];
  int          m_len = 0;
  int          m_cnt = 0;
  bit          m_ready = 0;
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  bit          m_acc = 0;

  function automatic logic [63:0] ref_pack(input int v [4]);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w = w | ((64'(v[i]) & 64'hFFFF) << (16 * i));
    return w;
  endfunction

  function automatic logic [10:0] dut_st();
    return {u_if.in_ready, busy, done, len_err, wr_cnt};
  endfunction

  function automatic logic [10:0] exp_st();
    return {m_ready, m_busy, m_done, m_err, 7'(m_cnt)};
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit was_done;
    bit nd;
    was_done = m_done;
    nd = 0;
    m_acc = 0;
    if (rst) begin
      m_ready = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_err = 0;
      return;
    end
    if (m_ready && u_if.in_valid) begin
      m_mem[m_cnt] = ref_pack(cur);
      m_cnt++;
      m_acc = 1;
      if (m_cnt == m_len) begin m_ready = 0; nd = 1; end
    end else if (!m_busy && start) begin
      if (int'(frame_len) > DEPTH) m_err = 1;
      m_len = (int'(frame_len) > DEPTH) ? DEPTH : int'(frame_len);
      m_cnt = 0;
      m_busy = 1;
      if (m_len == 0) nd = 1;
      else m_ready = 1;
    end
    if (was_done) m_busy = 0;
    m_done = nd;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
    for (int i = 0; i < 4; i++) u_if.din_vec[i] = 16'(cur[i]);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 4; i++) begin
      cur[i] = int'($urandom_range(65535)) - 32768;
      u_if.din_vec[i] = 16'(cur[i]);
    end
  endtask

  // Producer: keeps an offered word until it is taken, otherwise maybe offers a new one.
  task automatic drive_prod(input int gap_pct);
    if (!(u_if.in_valid && !m_acc)) begin
      u_if.in_valid = ($urandom_range(99) >= gap_pct);
      rand_vec();
    end
  endtask

  task automatic read_word(input int a, output logic [63:0] d);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    cycle();
    rd_en = 1'b0;
    cycle();
    d = rd_data;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst = 1'b1; start = 1'b0; frame_len = '0; rd_en = 1'b0; rd_addr = '0;
    u_if.in_valid = 1'b0;
    set_vec(0, 0, 0, 0);
    repeat (3) cycle();
    checks++;
    if (dut_st() !== 11'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_st(), 11'h0);
    end
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL reset_rd_data got %h exp %h", rd_data, 64'h0);
    end
    rst = 1'b0;
    start = 1'b1; frame_len = 7'd8; cycle(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_vec(); u_if.in_valid = 1'b1; cycle();
    end
    u_if.in_valid = 1'b0;
    checks++;
    if (dut_st() !== exp_st()) begin
      errors++; $display("FAIL reset_prefill got %h exp %h", dut_st(), exp_st());
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (dut_st() !== exp_st()) begin
        errors++; $display("FAIL reset_midfill cyc %0d got %h exp %h", k, dut_st(), exp_st());
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (dut_st() !== exp_st()) begin
      errors++; $display("FAIL reset_after got %h exp %h", dut_st(), exp_st());
    end
    for (int a = 0; a < 3; a++) begin
      read_word(a, d);
      checks++;
      if (d !== m_mem[a]) begin
        errors++; $display("FAIL reset_ram_intact addr %0d got %h exp %h", a, d, m_mem[a]);
      end
    end
  endtask

  task automatic test_full_rate();
    logic [63:0] d;
    int n_done;
    int first;
    n_done = 0; first = -1;
    start = 1'b1; frame_len = 7'd4; cycle(); start = 1'b0;
    set_vec(1, -1, 2, -2);
    u_if.in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1 && k <= 4) rand_vec();
      if (k > 4) u_if.in_valid = 1'b0;
      cycle();
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
      checks++;
      if (dut_st() !== exp_st()) begin
        errors++; $display("FAIL full_rate_status cyc %0d got %h exp %h", k, dut_st(), exp_st());
      end
    end
    checks++;
    if (first !== 4) begin
      errors++; $display("FAIL full_rate_done_cycle got %0d exp %0d", first, 4);
    end
    checks++;
    if (n_done !== 1) begin
      errors++; $display("FAIL full_rate_done_count got %0d exp %0d", n_done, 1);
    end
    read_word(0, d);
    checks++;
    if (d !== 64'hFFFE_0002_FFFF_0001) begin
      errors++; $display("FAIL full_rate_word0 got %h exp %h", d, 64'hFFFE_0002_FFFF_0001);
    end
    read_word(3, d);
    checks++;
    if (d !== m_mem[3]) begin
      errors++; $display("FAIL full_rate_word3 got %h exp %h", d, m_mem[3]);
    end
  endtask

  task automatic test_gaps();
    logic [63:0] d;
    int n_done;
    n_done = 0;
    start = 1'b1; frame_len = 7'd3; cycle(); start = 1'b0;
    for (int c = 0; c < 300 && !m_done; c++) begin
      drive_prod(40);
      cycle();
      if (done === 1'b1) n_done++;
      checks++;
      if (dut_st() !== exp_st()) begin
        errors++; $display("FAIL gaps_status cyc %0d got %h exp %h", c, dut_st(), exp_st());
      end
    end
    checks++;
    if (!m_done) begin
      errors++; $display("FAIL gaps_timeout got %0d words exp %0d", m_cnt, 3);
    end
    u_if.in_valid = 1'b1;
    rand_vec();
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (done === 1'b1) n_done++;
      checks++;
      if (dut_st() !== exp_st()) begin
        errors++; $display("FAIL gaps_hold cyc %0d got %h exp %h", k, dut_st(), exp_st());
      end
    end
    u_if.in_valid = 1'b0;
    checks++;
    if (n_done !== 1) begin
      errors++; $display("FAIL gaps_done_count got %0d exp %0d", n_done, 1);
    end
    for (int a = 0; a < 4; a++) begin
      read_word(a, d);
      checks++;
      if (d !== m_mem[a]) begin
        errors++; $display("FAIL gaps_word addr %0d got %h exp %h", a, d, m_mem[a]);
      end
    end
  endtask

  task automatic test_zero_and_clamp();
    logic [63:0] d;
    int a;
    start = 1'b1; frame_len = 7'd0; cycle(); start = 1'b0;
    checks++;
    if (dut_st() !== exp_st()) begin
      errors++; $display("FAIL zero_len_done got %h exp %h", dut_st(), exp_st());
    end
    cycle();
    checks++;
    if (dut_st() !== exp_st()) begin
      errors++; $display("FAIL zero_len_idle got %h exp %h", dut_st(), exp_st());
    end
    read_word(0, d);
    checks++;
    if (d !== m_mem[0]) begin
      errors++; $display("FAIL zero_len_nowrite got %h exp %h", d, m_mem[0]);
    end
    start = 1'b1; frame_len = 7'd65; cycle(); start = 1'b0;
    checks++;
    if (dut_st() !== exp_st()) begin
      errors++; $display("FAIL clamp_start got %h exp %h", dut_st(), exp_st());
    end
    for (int c = 0; c < 1000 && !m_done; c++) begin
      drive_prod(25);
      cycle();
      checks++;
      if (dut_st() !== exp_st()) begin
        errors++; $display("FAIL clamp_status cyc %0d got %h exp %h", c, dut_st(), exp_st());
      end
    end
    checks++;
    if (wr_cnt !== 7'd64) begin
      errors++; $display("FAIL clamp_wr_cnt got %0d exp %0d", wr_cnt, 64);
    end
    u_if.in_valid = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      a = (k == 0) ? 63 : int'($urandom_range(63));
      read_word(a, d);
      checks++;
      if (d !== m_mem[a]) begin
        errors++; $display("FAIL clamp_word addr %0d got %h exp %h", a, d, m_mem[a]);
      end
    end
  endtask

  task automatic test_read_first();
    logic [63:0] old;
    logic [63:0] d;
    old = '0;
    start = 1'b1; frame_len = 7'd3; cycle(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_vec();
      u_if.in_valid = 1'b1;
      if (k == 2) begin
        rd_en = 1'b1; rd_addr = 6'd2; old = m_mem[2];
      end
      cycle();
    end
    u_if.in_valid = 1'b0;
    rd_en = 1'b0;
    cycle();
    checks++;
    if (rd_data !== old) begin
      errors++; $display("FAIL read_first_old got %h exp %h", rd_data, old);
    end
    read_word(2, d);
    checks++;
    if (d !== m_mem[2]) begin
      errors++; $display("FAIL read_first_new got %h exp %h", d, m_mem[2]);
    end
    rd_addr = AW'($urandom_range(63));
    repeat (3) cycle();
    checks++;
    if (rd_data !== m_mem[2]) begin
      errors++; $display("FAIL rd_data_hold got %h exp %h", rd_data, m_mem[2]);
    end
  endtask

  task automatic test_start_ignored();
    int n_done;
    n_done = 0;
    start = 1'b1; frame_len = 7'd5; cycle(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) begin
        rand_vec(); u_if.in_valid = 1'b1;
      end else begin
        u_if.in_valid = 1'b0;
      end
      start = (k == 2 || k == 4 || k == 5);
      frame_len = (k == 2) ? 7'd2 : 7'd7;
      cycle();
      start = 1'b0;
      if (done === 1'b1) n_done++;
      checks++;
      if (dut_st() !== exp_st()) begin
        errors++; $display("FAIL start_ignored cyc %0d got %h exp %h", k, dut_st(), exp_st());
      end
    end
    checks++;
    if (n_done !== 1) begin
      errors++; $display("FAIL start_ignored_done_count got %0d exp %0d", n_done, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    test_reset();
    test_full_rate();
    test_gaps();
    test_zero_and_clamp();
    test_read_first();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
